// File: rtl/sinfonia_bcd_pkg.sv
// Shared constants, state type and width helper for the BCD-to-binary converter.
package sinfonia_bcd_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB    = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  function automatic int bcd_w(input int n);
    return DIGIT_W * n;
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// Per-digit correction for reverse double-dabble: a shifted digit of 8 or more
// came from an odd tens position and loses 3 to stay a valid decimal digit.
module bcd_digit_sub3
  import sinfonia_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= ADJ_THRESH) ? din - ADJ_SUB : din;

endmodule

// File: rtl/reverse_double_dabble.sv
// Sequential BCD-to-binary converter: resolves one binary bit per clock by
// shifting the BCD word right into the binary register and correcting digits.
module reverse_double_dabble
  import sinfonia_bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_W      = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        bin,
  output logic                    err
);

  localparam int BCD_W = bcd_w(NUM_DIGITS);
  localparam int STEPS = BCD_W;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_r;
  logic [BCD_W-1:0] bin_r;
  logic             err_r;

  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bin_shift;
  logic             digit_err;

  // The BCD LSB falls into the binary register's MSB on every step.
  assign bcd_shift = {1'b0, bcd_r[BCD_W-1:1]};
  assign bin_shift = {bcd_r[0], bin_r[BCD_W-1:1]};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_sub3 u_sub3 (
      .din  (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    digit_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] > BCD_MAX) digit_err = 1'b1;
    end
  end

  // Invalid words still run all steps so latency never depends on the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bin       <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      bcd_r     <= '0;
      bin_r     <= '0;
      err_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bcd_r    <= bcd;
            bin_r    <= '0;
            cnt      <= '0;
            err_r    <= digit_err;
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd_r <= bcd_adj;
          bin_r <= bin_shift;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            out_valid <= 1'b1;
            bin       <= err_r ? '0 : BIN_W'(bin_shift);
            err       <= err_r;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
